// File: rtl/div_pkg.sv
// Shared definitions for the restoring-division sequencer and its ALU.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_IDX_W = 3;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_CHKZ = 3'd0;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd1;
    localparam logic [OP_W-1:0] OP_BGET = 3'd2;
    localparam logic [OP_W-1:0] OP_BSET = 3'd3;
    localparam logic [OP_W-1:0] OP_GE   = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd5;
    localparam logic [OP_W-1:0] OP_SETQ = 3'd6;
    localparam logic [OP_W-1:0] OP_NOP  = 3'd7;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CHKZ   = 4'd1,
        SHIFT  = 4'd2,
        GETBIT = 4'd3,
        SETBIT = 4'd4,
        CMP    = 4'd5,
        SUB    = 4'd6,
        SETQ   = 4'd7,
        DONE   = 4'd8
    } state_t;

endpackage

// File: rtl/div_seq_ctrl.sv
// Sequencer for 8-bit restoring division: drives the shared ALU one op per cycle
// and owns the R, Q, bit-index and scratch-bit registers.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned IDX_W = DIV_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_c,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_d
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_n, w_n_nxt;
    logic [WIDTH-1:0] r_d, w_d_nxt;
    logic [WIDTH-1:0] r_r, w_r_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [IDX_W-1:0] r_i, w_i_nxt;
    logic             r_bit, w_bit_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic             r_busy, r_done;

    // State and datapath registers; busy/done are registered decodes of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_i     <= '0;
            r_bit   <= 1'b0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_d     <= w_d_nxt;
            r_r     <= w_r_nxt;
            r_q     <= w_q_nxt;
            r_i     <= w_i_nxt;
            r_bit   <= w_bit_nxt;
            r_dbz   <= w_dbz_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Next-state, register updates and ALU operand selection
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_d_nxt     = r_d;
        w_r_nxt     = r_r;
        w_q_nxt     = r_q;
        w_i_nxt     = r_i;
        w_bit_nxt   = r_bit;
        w_dbz_nxt   = r_dbz;
        alu_op      = OP_NOP;
        alu_a       = '0;
        alu_b       = '0;
        alu_c       = '0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_n_nxt     = dividend;
                    w_d_nxt     = divisor;
                    w_r_nxt     = '0;
                    w_q_nxt     = '0;
                    w_dbz_nxt   = 1'b0;
                    w_i_nxt     = IDX_W'(WIDTH - 1);
                    w_state_nxt = CHKZ;
                end
            end
            CHKZ: begin
                alu_op = OP_CHKZ;
                alu_a  = r_d;
                if (alu_d == '0) begin
                    w_q_nxt     = '1;
                    w_r_nxt     = r_n;
                    w_dbz_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                alu_op      = OP_SHL;
                alu_a       = r_r;
                w_r_nxt     = alu_d;
                w_state_nxt = GETBIT;
            end
            GETBIT: begin
                alu_op      = OP_BGET;
                alu_b       = WIDTH'(r_i);
                alu_c       = r_n;
                w_bit_nxt   = alu_d[0];
                w_state_nxt = SETBIT;
            end
            SETBIT: begin
                alu_op      = OP_BSET;
                alu_a       = r_r;
                alu_c       = WIDTH'(r_bit);
                w_r_nxt     = alu_d;
                w_state_nxt = CMP;
            end
            CMP: begin
                alu_op = OP_GE;
                alu_a  = r_r;
                alu_c  = r_d;
                if (alu_d[0]) begin
                    w_state_nxt = SUB;
                end else if (r_i == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_i_nxt     = r_i - 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SUB: begin
                alu_op      = OP_SUB;
                alu_a       = r_r;
                alu_c       = r_d;
                w_r_nxt     = alu_d;
                w_state_nxt = SETQ;
            end
            SETQ: begin
                alu_op  = OP_SETQ;
                alu_a   = r_q;
                alu_b   = WIDTH'(r_i);
                w_q_nxt = alu_d;
                // Exit test precedes the decrement so i never wraps
                if (r_i == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_i_nxt     = r_i - 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl with a behavioural model of the shared ALU.
module tb_div_seq_ctrl;
    import div_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;
    logic [7:0] alu_a, alu_b, alu_c, alu_d;
    logic [2:0] alu_op;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
        int         nsub;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    div_seq_ctrl #(.WIDTH(8), .IDX_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_op      (alu_op),
        .alu_d       (alu_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        logic [7:0] t;
        t     = alu_a;
        alu_d = 8'd0;
        case (alu_op)
            OP_CHKZ: alu_d = alu_a;
            OP_SHL:  alu_d = 8'(alu_a << 1);
            OP_BGET: alu_d = {7'd0, alu_c[alu_b[2:0]]};
            OP_BSET: begin
                t[alu_b[2:0]] = alu_c[0];
                alu_d = t;
            end
            OP_GE:   alu_d = {7'd0, (alu_a >= alu_c)};
            OP_SUB:  alu_d = 8'(alu_a - alu_c);
            OP_SETQ: alu_d = alu_a | 8'(8'd1 << alu_b[2:0]);
            default: alu_d = 8'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] n, input logic [7:0] d);
        exp_t e;
        e.q = 8'd0; e.r = 8'd0; e.dbz = 1'b0; e.nsub = 0;
        if (d == 8'd0) begin
            e.q = 8'hFF; e.r = n; e.dbz = 1'b1; e.lat = 1;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                e.r = {e.r[6:0], n[i]};
                if (e.r >= d) begin
                    e.r    = 8'(e.r - d);
                    e.q[i] = 1'b1;
                    e.nsub++;
                end
            end
            e.lat = 1 + 32 + 2 * $countones(e.q);
        end
        return e;
    endfunction

    task automatic do_div(input logic [7:0] n, input logic [7:0] d, input bit poke);
        exp_t e;
        int   cyc, nlow, nsub;
        sb.push_back(model(n, d));
        @(negedge clk);
        dividend = n; divisor = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; nlow = 0; nsub = 0;
        check("busy_rise", busy, 1);
        check("chkz_op", alu_op, OP_CHKZ);
        check("chkz_a", alu_a, d);
        while (!done && cyc < 100) begin
            if (alu_op == OP_SUB) nsub++;
            @(posedge clk);
            #1 cyc++;
            if (!busy) nlow++;
            if (poke && cyc == 5) begin start = 1'b1; dividend = 8'd1; divisor = 8'd1; end
            if (poke && cyc == 6) start = 1'b0;
        end
        e = sb.pop_front();
        if (!done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", cyc, e.lat);
            check("busy_hold", nlow, 0);
            check("sub_visits", nsub, e.nsub);
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.dbz);
            check("done_op", alu_op, OP_NOP);
        end
        if (poke) begin start = 1'b1; dividend = 8'd2; divisor = 8'd1; end
        @(posedge clk);
        #1 start = 1'b0;
        check("done_pulse", done, 0);
        check("busy_fall", busy, 0);
        check("q_hold", quotient, e.q);
        check("r_hold", remainder, e.r);
        check("dbz_hold", div_by_zero, e.dbz);
        if (poke) begin
            @(posedge clk);
            #1 check("ignored_start", busy, 0);
        end
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_op", alu_op, OP_NOP);
        @(negedge clk);
        reset = 1'b0;

        do_div(8'd100, 8'd7, 1'b0);
        do_div(8'd255, 8'd1, 1'b0);
        do_div(8'd3, 8'd10, 1'b0);
        do_div(8'd5, 8'd0, 1'b0);
        do_div(8'd200, 8'd13, 1'b1);
        do_div(8'd9, 8'd3, 1'b0);
        do_div(8'd200, 8'd150, 1'b0);
        for (int k = 0; k < 6; k++)
            do_div(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

        // Mid-operation reset abandons the division without a done pulse
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        check("mid_rst_op", alu_op, OP_NOP);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no_resume", ndone, 0);
        do_div(8'd100, 8'd7, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing FSM for the 8-bit restoring-division datapath.
- Accepts a dividend/divisor pair and computes quotient and remainder by driving the shared combinational ALU one operation per cycle. The ALU operations are: zero check, shift, bit get, bit set, compare, subtract and quotient-bit set.
- Holds the R, Q, bit-index and scratch-bit registers.
- The ALU is a separate instance, wired to this block by the integrating top.

Parameters:
- WIDTH, 8, operand width. The only legal value is 8, because the ALU is fixed at 8 bits.
- IDX_W, 3, bit-index width, equal to log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  8  N; captured when start is accepted.
- divisor  in  8  D; captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; high only in DONE.
- quotient  out  8  Q register; valid from done, held until the next accepted start.
- remainder  out  8  R register; same validity as quotient.
- div_by_zero  out  1  set with done when D==0; held until the next accepted start.
- alu_a, alu_b, alu_c  out  8 each  ALU operands.
- alu_op  out  3  ALU opcode.
- alu_d  in  8  ALU result (combinational, same cycle).

Behaviour:
- Reset (asynchronous, active-high), including mid-operation:
  - state=IDLE.
  - quotient, remainder, div_by_zero, busy, done, internal i and bit all 0.
  - The operation in flight is abandoned; no done pulse.
- ALU port defaults in IDLE and DONE: alu_op=7 (invalid, ALU returns 0), alu_a=alu_b=alu_c=0.
- IDLE, start=1:
  - Latch N and D.
  - Clear R, Q, div_by_zero; set i=7.
  - Go to CHKZ.
- start outside IDLE is ignored; this includes the DONE cycle.
- Each state below names the ALU operation driven and the action taken at the next rising edge.
- CHKZ: op0, A=D.
  - If alu_d==0: Q=8'hFF, R=N, div_by_zero=1, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: op1, A=R. R<=alu_d. Go to GETBIT.
- GETBIT: op2, B=i, C=N. bit<=alu_d[0]. Go to SETBIT.
- SETBIT: op3, A=R, B=0, C={7'b0,bit}. R<=alu_d. Go to CMP.
- CMP: op4, A=R, C=D.
  - If alu_d[0]==1: go to SUB.
  - Otherwise, if i==0 go to DONE; else i<=i-1 and go to SHIFT.
- SUB: op5, A=R, C=D. R<=alu_d. Go to SETQ.
- SETQ: op6, A=Q, B=i. Q<=alu_d. Then: if i==0 go to DONE; else i<=i-1 and go to SHIFT.
- DONE: done=1 for one cycle, then IDLE.
- Latency, counting the edge that accepts start as edge 0:
  - done is visible after edge 1 + 4*8 + 2*popcount(Q).
  - For D==0, done is visible after edge 1.
  - busy rises after edge 0 and falls after the DONE cycle.
- Arithmetic is unsigned 8-bit.
  - R never exceeds D-1 after CMP/SUB, so the shift cannot lose a significant bit for D≤128.
  - For D>128 the ALU shift truncation is accepted. The result then equals the ALU-defined restoring algorithm; the bench compares against a model of this sequence, not against ideal division.
- i wraps never: the exit test at i==0 precedes the decrement.

Decomposition:
- Shared package div_pkg holds:
  - ALU opcode constants: OP_CHKZ=0, OP_SHL=1, OP_BGET=2, OP_BSET=3, OP_GE=4, OP_SUB=5, OP_SETQ=6, OP_NOP=7.
  - The state enum: IDLE, CHKZ, SHIFT, GETBIT, SETBIT, CMP, SUB, SETQ, DONE.
- The ALU opcode constants are shared with the ALU owner.
- No sub-module inside this block. The top div_unit_top instantiates div_seq_ctrl plus ALU.

Test Plan:
- 100/7 -> Q=14, R=2, div_by_zero=0; done after edge 39; busy high edges 0..39.
- 255/1 -> Q=255, R=0; done after edge 49.
- 3/10 -> Q=0, R=3; done after edge 33; the SUB and SETQ states are never visited.
- 5/0 -> div_by_zero=1, Q=8'hFF, R=5; done after edge 1; alu_op=0 in CHKZ.
- Start pulses while busy and in the DONE cycle are ignored, and outputs are unchanged. Then a fresh start in IDLE with 9/3 -> Q=3, R=0.
- Assert reset at edge 10 of 100/7 -> all outputs 0 immediately (asynchronous), no done. After release, 100/7 completes normally.
